// File: rtl/poly_bank_dpram.sv
// rtl/poly_bank_dpram.sv - banked true dual-port coefficient RAM with optional zero-fill sequencer
//
// Purpose:
//   NUM_BANKS independent DEPTH x DLEN true dual-port RAMs (DEPTH = 2^HLEN).
//   Both ports are read-first. On a same-address double write, port A wins.
//   Read data appears RD_LAT (1 or 2) cycles after an accepted access, with rv_x.
//   Writes also assert rv_x; their do_x is the pre-write word.
//   When POLY_BANK_CLEAR_EN is defined, a clear sequencer zero-fills all banks.
//   It takes DEPTH/2 cycles, writing the lower half via port A and the upper half via port B.
//
// Ports:
//   clk, reset_n      - single clock, asynchronous active-low reset (RAM contents are not reset)
//   en[k]             - bank k access enable for both ports
//   we_a[k], we_b[k]  - per-bank write enables
//   addr_a/addr_b     - packed addresses, bank k at [k*HLEN +: HLEN]
//   di_a/di_b         - packed write data, bank k at [k*DLEN +: DLEN]
//   do_a/do_b         - packed read data, held when no access completes
//   rv_a/rv_b         - per-bank read-data-valid
//   clr_start         - pulse requesting a zero-fill (ignored while busy or without the macro)
//   busy, clr_done    - clear in progress / one-cycle completion pulse
//
// Configuration macro: POLY_BANK_CLEAR_EN (requires HLEN >= 2)
module poly_bank_dpram #(
  parameter int DLEN      = 32,
  parameter int HLEN      = 7,
  parameter int NUM_BANKS = 4,
  parameter int RD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_BANKS-1:0]      en,
  input  logic [NUM_BANKS-1:0]      we_a,
  input  logic [NUM_BANKS-1:0]      we_b,
  input  logic [NUM_BANKS*HLEN-1:0] addr_a,
  input  logic [NUM_BANKS*HLEN-1:0] addr_b,
  input  logic [NUM_BANKS*DLEN-1:0] di_a,
  input  logic [NUM_BANKS*DLEN-1:0] di_b,
  output logic [NUM_BANKS*DLEN-1:0] do_a,
  output logic [NUM_BANKS*DLEN-1:0] do_b,
  output logic [NUM_BANKS-1:0]      rv_a,
  output logic [NUM_BANKS-1:0]      rv_b,
  input  logic                      clr_start,
  output logic                      busy,
  output logic                      clr_done
);

  localparam int DEPTH = 2 ** HLEN;

  logic            w_clearing;
  logic [HLEN-2:0] w_clr_cnt;

`ifdef POLY_BANK_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          r_state, w_state_nxt;
  logic [HLEN-2:0] r_cnt, w_cnt_nxt;
  logic            r_clr_done, w_clr_done_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_clr_done <= w_clr_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_clr_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // The counter covers half the depth; each port clears one half.
        if (r_cnt == '1) begin
          w_state_nxt    = S_IDLE;
          w_clr_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_clearing = (r_state == S_CLEAR);
  assign w_clr_cnt  = r_cnt;
  assign busy       = w_clearing;
  assign clr_done   = r_clr_done;
`else
  logic w_unused_clr_start;
  assign w_unused_clr_start = clr_start;
  assign w_clearing = 1'b0;
  assign w_clr_cnt  = '0;
  assign busy       = 1'b0;
  assign clr_done   = 1'b0;
`endif

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DLEN-1:0] r_mem [DEPTH];

    logic            w_acc, w_wr_a, w_wr_b;
    logic [HLEN-1:0] w_addr_a, w_addr_b;
    logic [DLEN-1:0] w_din_a, w_din_b;
    logic [DLEN-1:0] r_rd_a, r_rd_b;
    logic            r_rv1;
    logic [DLEN-1:0] w_do_a, w_do_b;
    logic            w_rv;

    // The clear sequencer owns both ports while running, so user accesses are dropped.
    assign w_acc    = en[g] & ~w_clearing;
    assign w_wr_a   = w_clearing | (w_acc & we_a[g]);
    assign w_wr_b   = w_clearing | (w_acc & we_b[g]);
    assign w_addr_a = w_clearing ? {1'b0, w_clr_cnt} : addr_a[g*HLEN +: HLEN];
    assign w_addr_b = w_clearing ? {1'b1, w_clr_cnt} : addr_b[g*HLEN +: HLEN];
    assign w_din_a  = w_clearing ? '0 : di_a[g*DLEN +: DLEN];
    assign w_din_b  = w_clearing ? '0 : di_b[g*DLEN +: DLEN];

    // Port A is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
      if (w_wr_b) r_mem[w_addr_b] <= w_din_b;
      if (w_wr_a) r_mem[w_addr_a] <= w_din_a;
    end

    // The non-blocking RAM update makes both read ports see the pre-write word.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_rd_a <= '0;
        r_rd_b <= '0;
        r_rv1  <= 1'b0;
      end else begin
        r_rv1 <= w_acc;
        if (w_acc) begin
          r_rd_a <= r_mem[w_addr_a];
          r_rd_b <= r_mem[w_addr_b];
        end
      end
    end

    if (RD_LAT == 2) begin : g_lat2
      logic [DLEN-1:0] r_do_a, r_do_b;
      logic            r_rv2;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_do_a <= '0;
          r_do_b <= '0;
          r_rv2  <= 1'b0;
        end else begin
          r_rv2 <= r_rv1;
          if (r_rv1) begin
            r_do_a <= r_rd_a;
            r_do_b <= r_rd_b;
          end
        end
      end
      assign w_do_a = r_do_a;
      assign w_do_b = r_do_b;
      assign w_rv   = r_rv2;
    end else begin : g_lat1
      assign w_do_a = r_rd_a;
      assign w_do_b = r_rd_b;
      assign w_rv   = r_rv1;
    end

    assign do_a[g*DLEN +: DLEN] = w_do_a;
    assign do_b[g*DLEN +: DLEN] = w_do_b;
    assign rv_a[g]              = w_rv;
    assign rv_b[g]              = w_rv;
  end

endmodule
